// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Memory-access stage and MEM/WB pipeline register of the 5-stage datapath.
//   Takes the EX/MEM register outputs and performs a data-memory load or store.
//   Each access takes LAT cycles. Non-memory ops pass through in one cycle.
//   While an access is in flight, stall holds upstream and bubbles are sent
//   to write-back.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset (aborts any access in flight)
//   W_in       write-back control, passed through
//   M_in       memory control: bit1 MemRead, bit0 MemWrite (2'b11 = store)
//   ALU_in     ALU result / byte address for memory ops
//   RD2_in     store data
//   WN_in      destination register number
//   W_out      registered write-back control
//   RD_out     registered load data (0 for non-loads and bubbles)
//   ALU_out    registered ALU result
//   WN_out     registered destination register
//   align_err  registered; memory op whose address had ALU_in[1:0] != 0
//   stall      combinational; upstream must hold its inputs stable
module mem_wb_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  W_in,
  input  logic [1:0]  M_in,
  input  logic [31:0] ALU_in,
  input  logic [31:0] RD2_in,
  input  logic [4:0]  WN_in,
  output logic [1:0]  W_out,
  output logic [31:0] RD_out,
  output logic [31:0] ALU_out,
  output logic [4:0]  WN_out,
  output logic        align_err,
  output logic        stall
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [CW-1:0] cnt;

  logic [31:0] mem [DEPTH];

  logic          mem_op;
  logic          is_store;
  logic          is_load;
  logic          done;
  logic [AW-1:0] idx;
  logic          unused_hi;

  // Output register of the stage
  logic [1:0]  w_p0;
  logic [31:0] rd_p0;
  logic [31:0] alu_p0;
  logic [4:0]  wn_p0;
  logic        align_p0;

  assign mem_op   = |M_in;
  assign is_store = M_in[0];
  assign is_load  = (M_in == 2'b10);

  // Byte address -> word index; upper bits ignored so addresses wrap.
  assign idx       = ALU_in[AW+1:2];
  assign unused_hi = ^ALU_in[31:AW+2];

  // done: the instruction at the inputs retires at the coming edge.
  always_comb begin
    done = 1'b0;
    if (state == BUSY) begin
      done = (cnt == CNT_LAST);
    end else begin
      done = !mem_op || (LAT == 1);
    end
  end

  assign stall = !done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      w_p0     <= '0;
      rd_p0    <= '0;
      alu_p0   <= '0;
      wn_p0    <= '0;
      align_p0 <= 1'b0;
    end else if (done) begin
      state    <= IDLE;
      cnt      <= '0;
      w_p0     <= W_in;
      rd_p0    <= is_load ? mem[idx] : 32'd0;
      alu_p0   <= ALU_in;
      wn_p0    <= WN_in;
      align_p0 <= mem_op && (ALU_in[1:0] != 2'b00);
    end else begin
      // Access still in flight: emit a bubble to write-back.
      w_p0     <= '0;
      rd_p0    <= '0;
      alu_p0   <= '0;
      wn_p0    <= '0;
      align_p0 <= 1'b0;
      if (state == IDLE) begin
        state <= BUSY;
        cnt   <= CW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Stores commit on their final edge only; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (!rst && done && is_store) begin
      mem[idx] <= RD2_in;
    end
  end

  assign W_out     = w_p0;
  assign RD_out    = rd_p0;
  assign ALU_out   = alu_p0;
  assign WN_out    = wn_p0;
  assign align_err = align_p0;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  w_in   [2];
  logic [1:0]  m_in   [2];
  logic [31:0] alu_in [2];
  logic [31:0] rd2_in [2];
  logic [4:0]  wn_in  [2];
  logic [1:0]  w_out  [2];
  logic [31:0] rd_out [2];
  logic [31:0] alu_out[2];
  logic [4:0]  wn_out [2];
  logic [1:0]  align_v;
  logic [1:0]  stall_v;

  int total = 0;
  int bad   = 0;
  int lat [2] = '{2, 4};

  // Reference data memory, one per DUT (word-indexed, 256 words)
  logic [31:0] refmem [2][256];

  mem_wb_stage #(.DEPTH(256), .AW(8), .LAT(2)) dut0 (
    .clk(clk), .rst(rst),
    .W_in(w_in[0]), .M_in(m_in[0]), .ALU_in(alu_in[0]), .RD2_in(rd2_in[0]), .WN_in(wn_in[0]),
    .W_out(w_out[0]), .RD_out(rd_out[0]), .ALU_out(alu_out[0]), .WN_out(wn_out[0]),
    .align_err(align_v[0]), .stall(stall_v[0])
  );

  mem_wb_stage #(.DEPTH(256), .AW(8), .LAT(4)) dut1 (
    .clk(clk), .rst(rst),
    .W_in(w_in[1]), .M_in(m_in[1]), .ALU_in(alu_in[1]), .RD2_in(rd2_in[1]), .WN_in(wn_in[1]),
    .W_out(w_out[1]), .RD_out(rd_out[1]), .ALU_out(alu_out[1]), .WN_out(wn_out[1]),
    .align_err(align_v[1]), .stall(stall_v[1])
  );

  task automatic set_nop(input int sel);
    w_in[sel] = 2'b00; m_in[sel] = 2'b00; alu_in[sel] = 32'd0;
    rd2_in[sel] = 32'd0; wn_in[sel] = 5'd0;
  endtask

  // Issue one instruction to DUT sel and follow it to retirement.
  // Reference: a memory op takes lat cycles (stall high on all but the last,
  // bubbles on those edges); a non-memory op takes one cycle.
  task automatic run_op(input int sel, input logic [1:0] w, input logic [1:0] m,
                        input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wn);
    int n;
    logic [7:0]  idx;
    logic [31:0] exp_rd;
    logic [71:0] exp_v, got;
    w_in[sel] = w; m_in[sel] = m; alu_in[sel] = alu; rd2_in[sel] = rd2; wn_in[sel] = wn;
    n      = (m != 2'b00) ? lat[sel] : 1;
    idx    = alu[9:2];
    exp_rd = (m == 2'b10) ? refmem[sel][idx] : 32'd0;
    exp_v  = {w, exp_rd, alu, wn, (m != 2'b00) && (alu[1:0] != 2'b00)};
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      total++;
      if (stall_v[sel] !== 1'(k < n - 1)) begin
        bad++;
        $display("FAIL stall dut%0d m=%b alu=%h cyc=%0d: got %b want %b",
                 sel, m, alu, k, stall_v[sel], 1'(k < n - 1));
      end
      @(posedge clk); #1;
      got = {w_out[sel], rd_out[sel], alu_out[sel], wn_out[sel], align_v[sel]};
      total++;
      if (k < n - 1) begin
        if (got !== 72'd0) begin
          bad++;
          $display("FAIL bubble dut%0d alu=%h cyc=%0d: got %h want 0", sel, alu, k, got);
        end
      end else if (got !== exp_v) begin
        bad++;
        $display("FAIL result dut%0d m=%b alu=%h: got %h want %h", sel, m, alu, got, exp_v);
      end
    end
    if (m[0]) refmem[sel][idx] = rd2;
    set_nop(sel);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_nop(0); set_nop(1);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      total++;
      if ({w_out[s], rd_out[s], alu_out[s], wn_out[s], align_v[s]} !== 72'd0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: got %h want 0", s,
                 {w_out[s], rd_out[s], alu_out[s], wn_out[s], align_v[s]});
      end
      total++;
      if (stall_v[s] !== 1'b0) begin
        bad++;
        $display("FAIL reset_stall dut%0d: got %b want 0", s, stall_v[s]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_nop;
    run_op(0, 2'b10, 2'b00, 32'h1234, 32'd0, 5'd5);
    run_op(1, 2'b10, 2'b00, 32'h1234, 32'd0, 5'd5);
    total++;
    if (alu_out[1] !== 32'h1234 || w_out[1] !== 2'b10 || wn_out[1] !== 5'd5) begin
      bad++;
      $display("FAIL nop_pass: got w=%b alu=%h wn=%0d want w=10 alu=1234 wn=5",
               w_out[1], alu_out[1], wn_out[1]);
    end
  endtask

  // Give the first 16 words of each memory a known value.
  task automatic init_mem;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        run_op(s, 2'($urandom), 2'b01, 32'(i) << 2, $urandom, 5'($urandom));
  endtask

  task automatic test_store_load;
    run_op(0, 2'b01, 2'b01, 32'h10, 32'hDEADBEEF, 5'd7);
    run_op(0, 2'b11, 2'b10, 32'h10, 32'd0, 5'd8);
    total++;
    if (rd_out[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL store_load: got %h want deadbeef", rd_out[0]);
    end
  endtask

  task automatic test_lat4_load;
    run_op(1, 2'b11, 2'b10, 32'h24, 32'd0, 5'd9);
  endtask

  task automatic test_align;
    run_op(0, 2'b01, 2'b10, 32'h13, 32'd0, 5'd11);
    total++;
    if (align_v[0] !== 1'b1 || rd_out[0] !== refmem[0][4]) begin
      bad++;
      $display("FAIL align: got err=%b rd=%h want err=1 rd=%h", align_v[0], rd_out[0], refmem[0][4]);
    end
    run_op(0, 2'b01, 2'b10, 32'h14, 32'd0, 5'd12);
  endtask

  task automatic test_wrap;
    run_op(0, 2'b01, 2'b01, 32'h400, 32'hA5, 5'd2);
    run_op(0, 2'b01, 2'b10, 32'h0, 32'd0, 5'd3);
    total++;
    if (rd_out[0] !== 32'hA5) begin
      bad++;
      $display("FAIL wrap: got %h want a5", rd_out[0]);
    end
  endtask

  task automatic test_store11;
    run_op(1, 2'b01, 2'b11, 32'h08, $urandom, 5'd4);
    run_op(1, 2'b01, 2'b10, 32'h08, 32'd0, 5'd4);
  endtask

  task automatic test_reset_mid_busy;
    w_in[1] = 2'b01; m_in[1] = 2'b01; alu_in[1] = 32'h20; rd2_in[1] = 32'h5; wn_in[1] = 5'd3;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({w_out[1], rd_out[1], alu_out[1], wn_out[1], align_v[1]} !== 72'd0) begin
      bad++;
      $display("FAIL reset_busy: got %h want 0",
               {w_out[1], rd_out[1], alu_out[1], wn_out[1], align_v[1]});
    end
    rst = 1'b0;
    set_nop(0); set_nop(1);
    run_op(1, 2'b01, 2'b10, 32'h20, 32'd0, 5'd6);
    total++;
    if (rd_out[1] === 32'h5 && refmem[1][8] !== 32'h5) begin
      bad++;
      $display("FAIL reset_abort: got %h want %h", rd_out[1], refmem[1][8]);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 80; i++) begin
      int s;
      logic [31:0] a;
      s = int'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      run_op(s, 2'($urandom), 2'($urandom), a, $urandom, 5'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    set_nop(0); set_nop(1);
    test_reset;
    test_nop;
    init_mem;
    test_store_load;
    test_lat4_load;
    test_align;
    test_wrap;
    test_store11;
    test_reset_mid_busy;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage plus MEM/WB pipeline register of the 5-stage datapath. Consumes the EX/MEM register outputs (W, M, ALU result, RD2, write-register number) and performs data-memory load/store with a parameterised access latency. Stalls upstream while an access is in flight. Presents registered W, load data, ALU result and WN to the write-back stage.

Parameters:
DEPTH, 256, data-memory size in 32-bit words (power of two)
AW, 8, word-index width, log2(DEPTH)
LAT, 2, cycles per load/store access (>=1); non-memory ops always take 1 cycle

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
W_in  input  2  write-back control from EX/MEM, passed through
M_in  input  2  memory control: bit1 MemRead, bit0 MemWrite
ALU_in  input  32  ALU result; byte address for memory ops
RD2_in  input  32  store data
WN_in  input  5  destination register number
W_out  output  2  registered write-back control
RD_out  output  32  registered load data
ALU_out  output  32  registered ALU result
WN_out  output  5  registered destination register
align_err  output  1  registered; 1 for the instruction whose memory op had ALU_in[1:0]!=0
stall  output  1  combinational; 1 = upstream must hold EX/MEM inputs stable

Behaviour:
- Reset (rst=1 at posedge): W_out=0, RD_out=0, ALU_out=0, WN_out=0, align_err=0, state=IDLE, cnt=0. Memory contents are not reset. Reset mid-access aborts it: a pending store is not committed and no result is produced.
- Word index = ALU_in[AW+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4. Low two bits are ignored for the access. align_err is set for that instruction's result.
- Memory op = M_in!=0. M_in=2'b11 is treated as a store, with RD_out=0.
- FSM states: IDLE, BUSY. Counter cnt has width enough for LAT-1.
- IDLE, no memory op: stall=0. On the next edge W/ALU/WN are copied to the outputs, RD_out=0, align_err=0. Latency is 1 cycle, as for a plain pipeline register.
- IDLE, memory op, LAT=1: stall=0. The access completes at the next edge.
- IDLE, memory op, LAT>1: stall=1. At the edge, go to BUSY with cnt=1 and insert a bubble (W_out=0, WN_out=0, RD_out=0, ALU_out=0, align_err=0).
- BUSY, cnt<LAT-1: stall=1. At the edge cnt++ and another bubble is inserted. Inputs are held stable by upstream.
- BUSY, cnt==LAT-1: stall=0. At the edge the access completes and the state returns to IDLE with cnt=0.
- Completion:
  - Store: mem[idx] <= RD2_in and RD_out=0.
  - Load: RD_out <= mem[idx] (old contents).
  - In both cases W_out, ALU_out and WN_out take the input values.
- Each memory op occupies exactly LAT cycles, with stall high for the first LAT-1 of them. Back-to-back memory ops re-enter BUSY immediately after IDLE.
- Store followed by a load to the same word in the next instruction: the load returns the new value, because the store is committed at the earlier edge.
- No x is ever driven on any output.

Test Plan:
- Reset, then a non-memory op with W_in=2'b10, ALU_in=0x1234, WN_in=5 -> next cycle W_out=2'b10, ALU_out=0x1234, WN_out=5, RD_out=0, stall never asserted.
- LAT=2: store M_in=01, ALU_in=0x10, RD2_in=0xDEADBEEF, then load M_in=10, ALU_in=0x10 -> stall high 1 cycle per op, one bubble each (W_out=0), load result RD_out=0xDEADBEEF.
- LAT=4 load -> stall high exactly 3 consecutive cycles, 3 bubbles, result on the 4th edge.
- rst asserted during BUSY of a store to 0x20 (value 0x5) -> all outputs 0 next cycle, state IDLE, later load of 0x20 returns the prior contents (not 0x5).
- Load at ALU_in=0x13 -> reads word index 4, align_err=1 for that result only.
- DEPTH=256: store 0xA5 to address 0x400, then load address 0x0 -> RD_out=0xA5 (wrap-around).
